// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: digit pattern table, blank pattern and checker state type.
// Segment order is {a,b,c,d,e,f,g} with bit6 = a, active-high.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Packed so SEG_DIGIT[n] is the pattern for digit n; listed 9 down to 0.
   localparam logic [9:0][6:0] SEG_DIGIT = {
      7'b1111011,
      7'b1111111,
      7'b1110000,
      7'b1011111,
      7'b1011011,
      7'b0110011,
      7'b1111001,
      7'b1101101,
      7'b0110000,
      7'b1111110
   };

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } chk_state_t;

   function automatic logic [3:0] next_bcd(input logic [3:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational inverse of the BCD 7-segment encoder: seg pattern -> {hit, digit}.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic       hit,
   output logic [3:0] digit
);

   // Exact match against the shared pattern table; anything else is a miss.
   always_comb begin
      hit   = 1'b0;
      digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (seg == SEG_DIGIT[i]) begin
            hit   = 1'b1;
            digit = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg7_decode_checker.sv
// Receive-side 7-segment monitor: stability filter, decode, mod-10 up-count check, error counter.
// Define SEG7_CHK_BLANK_EN to accept the all-off pattern as a silent "blank" instead of an error.
module seg7_decode_checker
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 1,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       seg,
   output logic [3:0]       digit,
   output logic             digit_valid,
   output logic             pattern_err,
   output logic             seq_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

   logic [6:0] samp;
   logic [3:0] run;
   logic       first;
   logic       pending;
   chk_state_t state;

   logic       new_run;
   logic [3:0] run_next;
   logic       accept_next;
   logic       dec_hit;
   logic [3:0] dec_digit;
   logic       is_blank;
   logic       take_valid;
   logic       take_perr;
   logic       take_serr;

   seg7_to_bcd u_dec (
      .seg   (samp),
      .hit   (dec_hit),
      .digit (dec_digit)
   );

`ifdef SEG7_CHK_BLANK_EN
   assign is_blank = (samp == SEG_BLANK);
`else
   assign is_blank = 1'b0;
`endif

   // Run length of equal samples; accept fires once, on the edge the run first reaches RUN_MAX.
   always_comb begin
      new_run = first || (seg != samp);
      if (new_run)
         run_next = 4'd1;
      else if (run >= RUN_MAX)
         run_next = RUN_MAX;
      else
         run_next = run + 4'd1;
      accept_next = (run_next == RUN_MAX) && (new_run || (run != RUN_MAX));
   end

   // The last accepted digit doubles as the sequence reference while LOCKED.
   always_comb begin
      take_valid = pending && !is_blank && dec_hit;
      take_perr  = pending && !is_blank && !dec_hit;
      take_serr  = take_valid && (state == LOCKED) && (dec_digit != next_bcd(digit));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         samp        <= 7'd0;
         run         <= 4'd0;
         first       <= 1'b1;
         pending     <= 1'b0;
         state       <= UNLOCKED;
         digit       <= 4'd0;
         digit_valid <= 1'b0;
         pattern_err <= 1'b0;
         seq_err     <= 1'b0;
         err_count   <= '0;
      end else begin
         samp        <= seg;
         run         <= run_next;
         first       <= 1'b0;
         pending     <= accept_next;
         digit_valid <= take_valid;
         pattern_err <= take_perr;
         seq_err     <= take_serr;
         if (take_valid) begin
            digit <= dec_digit;
            state <= LOCKED;
         end else if (pending) begin
            state <= UNLOCKED;
         end
         if ((take_perr || take_serr) && (err_count != {ERR_W{1'b1}}))
            err_count <= err_count + 1'b1;
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_seg7_decode_checker.sv
// Directed self-checking bench: dut_a runs with S=1, ERR_W=8; dut_b with S=3, ERR_W=2.
module tb_seg7_decode_checker;

   localparam logic [6:0] PAT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                       7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

   logic       clk;
   logic       resetA, resetB;
   logic [6:0] segA, segB;
   logic [3:0] digitA, digitB;
   logic       validA, validB, perrA, perrB, serrA, serrB, lockA, lockB;
   logic [7:0] errA;
   logic [1:0] errB;

   int tests;
   int fails;

   seg7_decode_checker #(.STABLE_CYCLES(1), .ERR_W(8)) dut_a (
      .clk(clk), .reset(resetA), .seg(segA), .digit(digitA), .digit_valid(validA),
      .pattern_err(perrA), .seq_err(serrA), .locked(lockA), .err_count(errA)
   );

   seg7_decode_checker #(.STABLE_CYCLES(3), .ERR_W(2)) dut_b (
      .clk(clk), .reset(resetB), .seg(segB), .digit(digitB), .digit_valid(validB),
      .pattern_err(perrB), .seq_err(serrB), .locked(lockB), .err_count(errB)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetA = 1'b0;
      resetB = 1'b0;
      segA = PAT[4];
      tick();
      tick();
      tests++; if (digitA !== 4'd0) begin fails++; $display("[TB] FAIL reset_digit got %0d want 0", digitA); end
      tests++; if (validA !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b want 0", validA); end
      tests++; if (perrA !== 1'b0 || serrA !== 1'b0) begin fails++; $display("[TB] FAIL reset_errs got %b%b want 00", perrA, serrA); end
      tests++; if (lockA !== 1'b0) begin fails++; $display("[TB] FAIL reset_locked got %b want 0", lockA); end
      tests++; if (errA !== 8'd0) begin fails++; $display("[TB] FAIL reset_errcount got %0d want 0", errA); end
   endtask

   task automatic test_count_sequence();
      resetA = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         if (i < 12) segA = PAT[i % 10];
         tick();
         if (i > 0) begin
            tests++;
            if (validA !== 1'b1 || digitA !== 4'((i - 1) % 10) || serrA !== 1'b0 || perrA !== 1'b0 || lockA !== 1'b1) begin
               fails++;
               $display("[TB] FAIL count_step%0d got v=%b d=%0d se=%b pe=%b l=%b want v=1 d=%0d se=0 pe=0 l=1",
                        i - 1, validA, digitA, serrA, perrA, lockA, (i - 1) % 10);
            end
         end
      end
      tests++; if (errA !== 8'd0) begin fails++; $display("[TB] FAIL count_errcount got %0d want 0", errA); end
   endtask

   task automatic test_seq_error();
      segA = PAT[2]; tick();
      segA = PAT[3]; tick();
      segA = PAT[7]; tick();
      tests++; if (digitA !== 4'd3 || lockA !== 1'b1) begin fails++; $display("[TB] FAIL seq_locked3 got d=%0d l=%b want d=3 l=1", digitA, lockA); end
      segA = PAT[8]; tick();
      tests++;
      if (digitA !== 4'd7 || validA !== 1'b1 || serrA !== 1'b1 || errA !== 8'd1) begin
         fails++;
         $display("[TB] FAIL seq_jump7 got d=%0d v=%b se=%b e=%0d want d=7 v=1 se=1 e=1", digitA, validA, serrA, errA);
      end
      tick();
      tests++;
      if (digitA !== 4'd8 || validA !== 1'b1 || serrA !== 1'b0 || errA !== 8'd1) begin
         fails++;
         $display("[TB] FAIL seq_resync8 got d=%0d v=%b se=%b e=%0d want d=8 v=1 se=0 e=1", digitA, validA, serrA, errA);
      end
      tick();
      tests++; if (validA !== 1'b0) begin fails++; $display("[TB] FAIL seq_hold_noreaccept got v=%b want 0", validA); end
   endtask

   task automatic test_pattern_error();
      segA = 7'h55; tick();
      segA = PAT[2]; tick();
      tests++;
      if (perrA !== 1'b1 || lockA !== 1'b0 || digitA !== 4'd8 || validA !== 1'b0 || errA !== 8'd2) begin
         fails++;
         $display("[TB] FAIL perr_illegal got pe=%b l=%b d=%0d v=%b e=%0d want pe=1 l=0 d=8 v=0 e=2", perrA, lockA, digitA, validA, errA);
      end
      tick();
      tests++;
      if (validA !== 1'b1 || digitA !== 4'd2 || lockA !== 1'b1 || serrA !== 1'b0 || errA !== 8'd2) begin
         fails++;
         $display("[TB] FAIL perr_relock got v=%b d=%0d l=%b se=%b e=%0d want v=1 d=2 l=1 se=0 e=2", validA, digitA, lockA, serrA, errA);
      end
   endtask

   task automatic test_stability_filter();
      logic [3:0] seq [8] = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6};
      resetB = 1'b1;
      for (int i = 0; i < 8; i++) begin
         segB = PAT[seq[i]];
         tick();
         tests++;
         if (validB !== (i == 5)) begin
            fails++;
            $display("[TB] FAIL filter_edge%0d got v=%b want %b", i, validB, (i == 5));
         end
         if (i == 5) begin
            tests++;
            if (digitB !== 4'd6 || lockB !== 1'b1) begin fails++; $display("[TB] FAIL filter_digit got d=%0d l=%b want d=6 l=1", digitB, lockB); end
         end
      end
   endtask

   task automatic test_err_saturation();
      for (int k = 0; k <= 5; k++) begin
         if (k < 5) segB = (k % 2 == 0) ? 7'h55 : 7'h2A;
         tick();
         if (k > 0) begin
            tests++;
            if (perrB !== 1'b1 || errB !== 2'((k > 3) ? 3 : k)) begin
               fails++;
               $display("[TB] FAIL sat_err%0d got pe=%b e=%0d want pe=1 e=%0d", k, perrB, errB, (k > 3) ? 3 : k);
            end
         end
         if (k < 5) begin
            tick();
            tick();
         end
      end
   endtask

   task automatic test_reset_mid_run_and_blank();
      segB = PAT[7]; tick(); tick();
      resetB = 1'b0; tick();
      tests++;
      if (digitB !== 4'd0 || validB !== 1'b0 || perrB !== 1'b0 || serrB !== 1'b0 || lockB !== 1'b0 || errB !== 2'd0) begin
         fails++;
         $display("[TB] FAIL midreset_clear got d=%0d v=%b pe=%b se=%b l=%b e=%0d want all 0", digitB, validB, perrB, serrB, lockB, errB);
      end
      tick();
      resetB = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++;
         if (validB !== (i == 3)) begin fails++; $display("[TB] FAIL midreset_fresh%0d got v=%b want %b", i, validB, (i == 3)); end
      end
      tests++; if (digitB !== 4'd7 || lockB !== 1'b1) begin fails++; $display("[TB] FAIL midreset_digit got d=%0d l=%b want d=7 l=1", digitB, lockB); end
      segB = 7'h00;
      for (int i = 0; i < 4; i++) tick();
`ifdef SEG7_CHK_BLANK_EN
      tests++;
      if (perrB !== 1'b0 || validB !== 1'b0 || lockB !== 1'b0 || digitB !== 4'd7 || errB !== 2'd0) begin
         fails++;
         $display("[TB] FAIL blank_en got pe=%b v=%b l=%b d=%0d e=%0d want pe=0 v=0 l=0 d=7 e=0", perrB, validB, lockB, digitB, errB);
      end
`else
      tests++;
      if (perrB !== 1'b1 || validB !== 1'b0 || lockB !== 1'b0 || digitB !== 4'd7 || errB !== 2'd1) begin
         fails++;
         $display("[TB] FAIL blank_dis got pe=%b v=%b l=%b d=%0d e=%0d want pe=1 v=0 l=0 d=7 e=1", perrB, validB, lockB, digitB, errB);
      end
`endif
   endtask

   // Scenarios run in order; dut_a and dut_b each carry state from one task into the next.
   initial begin
      clk = 1'b0;
      resetA = 1'b0;
      resetB = 1'b0;
      segA = 7'd0;
      segB = 7'd0;
      tests = 0;
      fails = 0;
      test_reset();
      test_count_sequence();
      test_seq_error();
      test_pattern_error();
      test_stability_filter();
      test_err_saturation();
      test_reset_mid_run_and_blank();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
